// File: rtl/btn_pkg.sv
// Shared definitions for the push-button front end: bit positions,
// direction codes and the per-channel debounce state type.
package btn_pkg;

    localparam int BTN_U = 3;
    localparam int BTN_D = 2;
    localparam int BTN_L = 1;
    localparam int BTN_R = 0;

    typedef enum logic [1:0] {
        DIR_U = 2'd0,
        DIR_D = 2'd1,
        DIR_L = 2'd2,
        DIR_R = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } chan_state_e;

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One button channel: two-flop synchroniser followed by a debounce FSM.
// Produces a clean level and one-cycle press/release pulses.
module debounce_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    chan_state_e      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
        end
    end

    // A single contrary sample in either wait state throws away the count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_sync) begin
                        r_state <= PRESS_WAIT;
                        r_cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!r_sync) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == LAST_CNT) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                        r_press <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!r_sync) begin
                        r_state <= RELEASE_WAIT;
                        r_cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (r_sync) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                    end else if (r_cnt == LAST_CNT) begin
                        r_state   <= IDLE;
                        r_cnt     <= '0;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the four game buttons and turns fresh presses into a single
// prioritised direction request (U > D > L > R).
module button_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_btn_raw,
    output logic [3:0] o_btn_level,
    output logic [3:0] o_btn_press,
    output logic [3:0] o_btn_release,
    output logic       o_dir_valid,
    output logic [1:0] o_dir_code
);

    logic [3:0] w_level;
    logic [3:0] w_press;
    logic [3:0] w_release;
    dir_e       w_dir_code;
    logic       r_dir_valid;
    dir_e       r_dir_code;

    for (genvar g = 0; g < 4; g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_chan (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_raw    (i_btn_raw[g]),
            .o_level  (w_level[g]),
            .o_press  (w_press[g]),
            .o_release(w_release[g])
        );
    end

    always_comb begin
        w_dir_code = DIR_U;
        if (w_press[BTN_U]) begin
            w_dir_code = DIR_U;
        end else if (w_press[BTN_D]) begin
            w_dir_code = DIR_D;
        end else if (w_press[BTN_L]) begin
            w_dir_code = DIR_L;
        end else if (w_press[BTN_R]) begin
            w_dir_code = DIR_R;
        end
    end

    // The code register only loads on a press so consumers see it hold.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dir_valid <= 1'b0;
            r_dir_code  <= DIR_U;
        end else begin
            r_dir_valid <= |w_press;
            if (|w_press) begin
                r_dir_code <= w_dir_code;
            end
        end
    end

    assign o_btn_level   = w_level;
    assign o_btn_press   = w_press;
    assign o_btn_release = w_release;
    assign o_dir_valid   = r_dir_valid;
    assign o_dir_code    = r_dir_code;

endmodule

// File: tb/tb_button_conditioner.sv
// Scenario bench for button_conditioner with a short debounce window;
// expected pulses are queued per absolute cycle and checked every cycle.
module tb_button_conditioner;

    localparam int DEB = 4;

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic       dv;
        logic [1:0] code;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] i_btn_raw = 4'b0000;
    logic [3:0] o_btn_level;
    logic [3:0] o_btn_press;
    logic [3:0] o_btn_release;
    logic       o_dir_valid;
    logic [1:0] o_dir_code;

    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    int         base;
    exp_t       sb[$];
    exp_t       item;
    logic [3:0] stim[$];
    logic [3:0] expPress;
    logic [3:0] expRel;
    logic       expDv;
    logic [1:0] expCode = 2'd0;
    logic [3:0] expLevel = 4'b0000;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (3)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_btn_raw    (i_btn_raw),
        .o_btn_level  (o_btn_level),
        .o_btn_press  (o_btn_press),
        .o_btn_release(o_btn_release),
        .o_dir_valid  (o_dir_valid),
        .o_dir_code   (o_dir_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Input set at negedge of cycle c is sampled at edge c+1; a pulse due
    // at edge e is visible at the negedge where cyc == e.
    task automatic test_reset;
        rst = 1'b1;
        i_btn_raw = 4'b0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({o_btn_level, o_btn_press, o_btn_release, o_dir_valid, o_dir_code} !== 15'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_state got %b want 0", {o_btn_level, o_btn_press, o_btn_release, o_dir_valid, o_dir_code});
        end
        rst = 1'b0;
        expLevel = 4'b0000;
        expCode = 2'd0;
    endtask

    task automatic test_clean_press;
        base = cyc + 1;
        stim.delete();
        for (int i = 0; i < 22; i++) stim.push_back(i < 12 ? 4'b1000 : 4'b0000);
        sb.push_back('{base + 7, 4'b1000, 4'b0000, 1'b0, 2'd0});
        sb.push_back('{base + 8, 4'b0000, 4'b0000, 1'b1, 2'd0});
        sb.push_back('{base + 19, 4'b0000, 4'b1000, 1'b0, 2'd0});
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            expPress = '0; expRel = '0; expDv = 1'b0;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                item = sb.pop_front();
                expPress = item.press; expRel = item.rel; expDv = item.dv;
                if (item.dv) expCode = item.code;
            end
            expLevel = (expLevel | expPress) & ~expRel;
            vectors++;
            if ({o_btn_press, o_btn_release, o_dir_valid, o_dir_code, o_btn_level} !== {expPress, expRel, expDv, expCode, expLevel}) begin
                miscompares++;
                $display("[TB] FAIL clean_press cyc=%0d got p=%b r=%b v=%b c=%0d l=%b want p=%b r=%b v=%b c=%0d l=%b",
                         cyc, o_btn_press, o_btn_release, o_dir_valid, o_dir_code, o_btn_level, expPress, expRel, expDv, expCode, expLevel);
            end
            i_btn_raw = stim[i];
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL clean_press_pending got %0d events left want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_bounce;
        base = cyc + 1;
        stim.delete();
        for (int i = 0; i < 28; i++) stim.push_back((i < 15 && i != 1 && i != 4) ? 4'b0001 : 4'b0000);
        sb.push_back('{base + 12, 4'b0001, 4'b0000, 1'b0, 2'd0});
        sb.push_back('{base + 13, 4'b0000, 4'b0000, 1'b1, 2'd3});
        sb.push_back('{base + 22, 4'b0000, 4'b0001, 1'b0, 2'd0});
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            expPress = '0; expRel = '0; expDv = 1'b0;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                item = sb.pop_front();
                expPress = item.press; expRel = item.rel; expDv = item.dv;
                if (item.dv) expCode = item.code;
            end
            expLevel = (expLevel | expPress) & ~expRel;
            vectors++;
            if ({o_btn_press, o_btn_release, o_dir_valid, o_dir_code, o_btn_level} !== {expPress, expRel, expDv, expCode, expLevel}) begin
                miscompares++;
                $display("[TB] FAIL bounce cyc=%0d got p=%b r=%b v=%b c=%0d l=%b want p=%b r=%b v=%b c=%0d l=%b",
                         cyc, o_btn_press, o_btn_release, o_dir_valid, o_dir_code, o_btn_level, expPress, expRel, expDv, expCode, expLevel);
            end
            i_btn_raw = stim[i];
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL bounce_pending got %0d events left want 0", sb.size());
            sb.delete();
        end
    endtask

    // The one-sample glitch lands on the edge just before the release would complete.
    task automatic test_release;
        base = cyc + 1;
        stim.delete();
        for (int i = 0; i < 28; i++) stim.push_back((i < 12 || i == 15) ? 4'b0010 : 4'b0000);
        sb.push_back('{base + 7, 4'b0010, 4'b0000, 1'b0, 2'd0});
        sb.push_back('{base + 8, 4'b0000, 4'b0000, 1'b1, 2'd2});
        sb.push_back('{base + 23, 4'b0000, 4'b0010, 1'b0, 2'd0});
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            expPress = '0; expRel = '0; expDv = 1'b0;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                item = sb.pop_front();
                expPress = item.press; expRel = item.rel; expDv = item.dv;
                if (item.dv) expCode = item.code;
            end
            expLevel = (expLevel | expPress) & ~expRel;
            vectors++;
            if ({o_btn_press, o_btn_release, o_dir_valid, o_dir_code, o_btn_level} !== {expPress, expRel, expDv, expCode, expLevel}) begin
                miscompares++;
                $display("[TB] FAIL release cyc=%0d got p=%b r=%b v=%b c=%0d l=%b want p=%b r=%b v=%b c=%0d l=%b",
                         cyc, o_btn_press, o_btn_release, o_dir_valid, o_dir_code, o_btn_level, expPress, expRel, expDv, expCode, expLevel);
            end
            i_btn_raw = stim[i];
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL release_pending got %0d events left want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_simultaneous;
        base = cyc + 1;
        stim.delete();
        for (int i = 0; i < 22; i++) stim.push_back(i < 12 ? 4'b0101 : 4'b0000);
        sb.push_back('{base + 7, 4'b0101, 4'b0000, 1'b0, 2'd0});
        sb.push_back('{base + 8, 4'b0000, 4'b0000, 1'b1, 2'd1});
        sb.push_back('{base + 19, 4'b0000, 4'b0101, 1'b0, 2'd0});
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            expPress = '0; expRel = '0; expDv = 1'b0;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                item = sb.pop_front();
                expPress = item.press; expRel = item.rel; expDv = item.dv;
                if (item.dv) expCode = item.code;
            end
            expLevel = (expLevel | expPress) & ~expRel;
            vectors++;
            if ({o_btn_press, o_btn_release, o_dir_valid, o_dir_code, o_btn_level} !== {expPress, expRel, expDv, expCode, expLevel}) begin
                miscompares++;
                $display("[TB] FAIL simultaneous cyc=%0d got p=%b r=%b v=%b c=%0d l=%b want p=%b r=%b v=%b c=%0d l=%b",
                         cyc, o_btn_press, o_btn_release, o_dir_valid, o_dir_code, o_btn_level, expPress, expRel, expDv, expCode, expLevel);
            end
            i_btn_raw = stim[i];
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL simultaneous_pending got %0d events left want 0", sb.size());
            sb.delete();
        end
    endtask

    // R is pressed and U is mid-qualification when reset hits; both are held through it.
    task automatic test_reset_mid;
        base = cyc + 1;
        stim.delete();
        for (int i = 0; i < 36; i++) stim.push_back(i < 10 ? 4'b0001 : (i < 26 ? 4'b1001 : 4'b0000));
        sb.push_back('{base + 7, 4'b0001, 4'b0000, 1'b0, 2'd0});
        sb.push_back('{base + 8, 4'b0000, 4'b0000, 1'b1, 2'd3});
        sb.push_back('{base + 21, 4'b1001, 4'b0000, 1'b0, 2'd0});
        sb.push_back('{base + 22, 4'b0000, 4'b0000, 1'b1, 2'd0});
        sb.push_back('{base + 33, 4'b0000, 4'b1001, 1'b0, 2'd0});
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            expPress = '0; expRel = '0; expDv = 1'b0;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                item = sb.pop_front();
                expPress = item.press; expRel = item.rel; expDv = item.dv;
                if (item.dv) expCode = item.code;
            end
            expLevel = (expLevel | expPress) & ~expRel;
            vectors++;
            if ({o_btn_press, o_btn_release, o_dir_valid, o_dir_code, o_btn_level} !== {expPress, expRel, expDv, expCode, expLevel}) begin
                miscompares++;
                $display("[TB] FAIL reset_mid cyc=%0d got p=%b r=%b v=%b c=%0d l=%b want p=%b r=%b v=%b c=%0d l=%b",
                         cyc, o_btn_press, o_btn_release, o_dir_valid, o_dir_code, o_btn_level, expPress, expRel, expDv, expCode, expLevel);
            end
            if (i == 14) begin
                #1 rst = 1'b1;
                #1;
                vectors++;
                if ({o_btn_level, o_btn_press, o_btn_release, o_dir_valid, o_dir_code} !== 15'd0) begin
                    miscompares++;
                    $display("[TB] FAIL reset_async got %b want 0", {o_btn_level, o_btn_press, o_btn_release, o_dir_valid, o_dir_code});
                end
                #1 rst = 1'b0;
                expLevel = 4'b0000;
                expCode = 2'd0;
            end
            i_btn_raw = stim[i];
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_pending got %0d events left want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_long_hold;
        base = cyc + 1;
        stim.delete();
        for (int i = 0; i < 1010; i++) stim.push_back(i < 1000 ? 4'b0100 : 4'b0000);
        sb.push_back('{base + 7, 4'b0100, 4'b0000, 1'b0, 2'd0});
        sb.push_back('{base + 8, 4'b0000, 4'b0000, 1'b1, 2'd1});
        sb.push_back('{base + 1007, 4'b0000, 4'b0100, 1'b0, 2'd0});
        for (int i = 0; i < 1010; i++) begin
            @(negedge clk);
            expPress = '0; expRel = '0; expDv = 1'b0;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                item = sb.pop_front();
                expPress = item.press; expRel = item.rel; expDv = item.dv;
                if (item.dv) expCode = item.code;
            end
            expLevel = (expLevel | expPress) & ~expRel;
            vectors++;
            if ({o_btn_press, o_btn_release, o_dir_valid, o_dir_code, o_btn_level} !== {expPress, expRel, expDv, expCode, expLevel}) begin
                miscompares++;
                $display("[TB] FAIL long_hold cyc=%0d got p=%b r=%b v=%b c=%0d l=%b want p=%b r=%b v=%b c=%0d l=%b",
                         cyc, o_btn_press, o_btn_release, o_dir_valid, o_dir_code, o_btn_level, expPress, expRel, expDv, expCode, expLevel);
            end
            i_btn_raw = stim[i];
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL long_hold_pending got %0d events left want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_simultaneous();
        test_reset_mid();
        test_long_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end conditioning for the four game push-buttons (up, down, left, right). It synchronises the raw pad inputs, debounces each one with a per-button state machine, and produces clean levels, single-cycle press pulses and a prioritised direction request. Its outputs feed the master and navigation state machines in place of the raw pads.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable synchronised samples required to accept a change (10 ms at 100 MHz); legal range ≥ 2.
- `CNT_W`, default 20: counter width; must satisfy 2^CNT_W ≥ `DEBOUNCE_CYCLES`.
- `CLK` input 1: system clock; all state updates on the rising edge.
- `RESET` input 1: asynchronous, active-high reset; not debounced here.
- `BTN_RAW` input 4: raw pad levels {U,D,L,R}, bit 3 = U, bit 0 = R; asynchronous to `CLK`.
- `BTN_LEVEL` output 4: debounced level per button, same bit order.
- `BTN_PRESS` output 4: one-cycle pulse on each accepted press.
- `BTN_RELEASE` output 4: one-cycle pulse on each accepted release.
- `DIR_VALID` output 1: one-cycle pulse when any `BTN_PRESS` bit is high.
- `DIR_CODE` output 2: encoded direction of the highest-priority press, U=0, D=1, L=2, R=3; holds its last value when `DIR_VALID` is low.

## Operation
- Synchronisation: each `BTN_RAW` bit passes through two flops to give a synchronised sample `s`. Reset value of both flops is 0.
- Each channel runs a four-state FSM with a counter `cnt`:
  - IDLE: released and stable. If `s`=1, go to PRESS_WAIT with `cnt`=0.
  - PRESS_WAIT:
    - If `s`=0, return to IDLE with `cnt`=0.
    - Else if `cnt`=`DEBOUNCE_CYCLES`-1, go to PRESSED: set `BTN_LEVEL`=1 and pulse `BTN_PRESS`.
    - Else increment `cnt`.
  - PRESSED: mirror of IDLE. If `s`=0, go to RELEASE_WAIT with `cnt`=0.
  - RELEASE_WAIT: mirror of PRESS_WAIT with `s` inverted. On completion go to IDLE: clear `BTN_LEVEL` and pulse `BTN_RELEASE`. If `s`=1 before completion, return to PRESSED.
- Any single contrary sample restarts qualification. A glitch therefore never produces an output change, however close to completion it occurs.
- `cnt` saturates by construction: it never exceeds `DEBOUNCE_CYCLES`-1 and never wraps.
- Direction request:
  - When any `BTN_PRESS` bit is high in a cycle, `DIR_VALID` pulses.
  - `DIR_CODE` takes the highest-priority set bit, priority U > D > L > R.
  - Lower-priority simultaneous presses are dropped from the direction request; their `BTN_PRESS` bits still pulse.
- Reset asserted at any time:
  - All FSMs go to IDLE and all counters clear.
  - All outputs go to 0, including `DIR_CODE`=0 (U).
  - A button held through reset release is reported as a fresh press after full qualification.

## Timing
- Press latency: raw rising edge sampled at clock edge k gives `BTN_PRESS` high in the cycle after edge k+`DEBOUNCE_CYCLES`+2. Breakdown:
  - 2 edges of synchronisation.
  - 1 edge for IDLE→PRESS_WAIT.
  - `DEBOUNCE_CYCLES` edges of counting.
- Release latency: identical and symmetric.
- `BTN_PRESS`, `BTN_RELEASE` and `DIR_VALID` are registered and high for exactly one cycle.
- `BTN_LEVEL` changes on the same edge as the corresponding pulse.
- `DIR_VALID` and `DIR_CODE` are registered from the pulse vector, so they lag `BTN_PRESS` by one cycle.
- Minimum spacing between two presses of one button is 2·(`DEBOUNCE_CYCLES`+1) cycles. No back-pressure: consumers must sample every cycle.

## Structure
- Shared package `btn_pkg`:
  - Bit indices `BTN_U`=3, `BTN_D`=2, `BTN_L`=1, `BTN_R`=0.
  - Direction codes `DIR_U`..`DIR_R`.
  - Channel state enum `{IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT}`.
- Sub-module `debounce_channel`: synchroniser, FSM and counter, producing level/press/release. It is instantiated four times by a generate loop.
- The top level holds only the priority encoder and the `DIR_VALID`/`DIR_CODE` registers.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- Clean press: U raw 0→1 sampled at edge 10, held → `BTN_PRESS[3]` high only in the cycle after edge 16, `BTN_LEVEL[3]`=1 from then, `DIR_VALID`=1 with `DIR_CODE`=0 one cycle later.
- Bounce: R raw toggles 1,0,1,1,0 on consecutive edges, then high for 10 cycles → exactly one `BTN_PRESS[0]`, asserted 6 edges after the final rising sample.
- Release: L held pressed, raw → 0 for 10 cycles → one `BTN_RELEASE[1]` 6 edges after the release sample, and `BTN_LEVEL[1]`=0 on that edge; no `DIR_VALID`.
- Simultaneous: D and R rise on the same edge → `BTN_PRESS`=4'b0101 for one cycle; one `DIR_VALID` with `DIR_CODE`=1.
- Reset mid-qualification: U enters PRESS_WAIT, `RESET` pulsed asynchronously between edges with U still held → all outputs 0 immediately; press reported 6 edges after the first edge following reset deassertion plus synchroniser refill, and never twice.
- Long hold: D held for 1000 cycles → exactly one `BTN_PRESS[2]`; `cnt` never exceeds 3.
